// File: rtl/vga_pkg.sv
// Shared VGA geometry, coordinate type and motion FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    localparam int H_VIS = 640;
    localparam int V_VIS = 480;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // A requested speed of zero would never move the sprite, so it runs at 1 px/frame.
    function automatic logic [2:0] min_speed(input logic [2:0] s);
        return (s == 3'd0) ? 3'd1 : s;
    endfunction

endpackage

// File: rtl/axis_stepper.sv
// Position, direction and wall bounce for one sprite axis, clamped to [0, LIMIT].
// Latency: pos/bounce registered, valid the cycle after step; at_wall is combinational.
// Backpressure: none; a step is applied in the cycle it is presented.
module axis_stepper #(
    parameter int LIMIT = 608,
    parameter int INIT  = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       load_home,
    input  logic [2:0] spd,
    output logic [9:0] pos,
    output logic       bounce,
    output logic       at_wall
);
    import vga_pkg::*;

    localparam logic signed [10:0] LIM_S  = 11'(LIMIT);
    localparam coord_t             LIM_C  = 10'(LIMIT);
    localparam coord_t             INIT_C = 10'(INIT);

    logic              dir_neg;
    logic signed [10:0] pos_s;
    logic signed [10:0] spd_s;
    logic signed [10:0] fwd;
    logic signed [10:0] rev;
    coord_t            pos_nxt;

    // Candidate next position; reaching or passing a wall clamps onto it and flags a hit.
    always_comb begin
        pos_s   = $signed({1'b0, pos});
        spd_s   = $signed({8'b0, spd});
        fwd     = pos_s + spd_s;
        rev     = pos_s - spd_s;
        at_wall = 1'b0;
        pos_nxt = pos;
        if (!dir_neg) begin
            if (fwd >= LIM_S) begin
                at_wall = 1'b1;
                pos_nxt = LIM_C;
            end else begin
                pos_nxt = fwd[9:0];
            end
        end else begin
            if (rev <= 11'sd0) begin
                at_wall = 1'b1;
                pos_nxt = '0;
            end else begin
                pos_nxt = rev[9:0];
            end
        end
    end

    // Commit a step, reversing direction on a wall hit; home snaps back to INIT moving +.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos     <= INIT_C;
            dir_neg <= 1'b0;
            bounce  <= 1'b0;
        end else begin
            bounce <= 1'b0;
            if (load_home) begin
                pos     <= INIT_C;
                dir_neg <= 1'b0;
            end else if (step) begin
                pos    <= pos_nxt;
                bounce <= at_wall;
                if (at_wall) begin
                    dir_neg <= ~dir_neg;
                end
            end
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Run/hold/idle sequencer moving one sprite per frame tick with wall bounce and hit count.
// Latency: all outputs registered; position and bounce pulses change the cycle after refr_tick.
// Backpressure: none; controls and ticks are acted on in the cycle they arrive (home > stop > start).
module sprite_motion_ctrl #(
    parameter int H_VIS  = 640,
    parameter int V_VIS  = 480,
    parameter int SPR_W  = 32,
    parameter int SPR_H  = 16,
    parameter int X_INIT = 300,
    parameter int Y_INIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refr_tick,
    input  logic       start,
    input  logic       stop,
    input  logic       home,
    input  logic [2:0] speed,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       moving,
    output logic       bounce_x,
    output logic       bounce_y,
    output logic [7:0] bounce_cnt
);
    import vga_pkg::*;

    localparam int X_MAX = H_VIS - SPR_W;
    localparam int Y_MAX = V_VIS - SPR_H;

    state_t     state;
    logic [2:0] spd_q;
    logic       step;
    logic       hit_x;
    logic       hit_y;
    logic [8:0] cnt_sum;
    logic [7:0] cnt_nxt;

    // Steps happen only on a tick in RUN that is not also leaving RUN.
    always_comb begin
        step    = (state == RUN) && refr_tick && !home && !stop;
        cnt_sum = {1'b0, bounce_cnt} + {8'b0, hit_x} + {8'b0, hit_y};
        cnt_nxt = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end

    axis_stepper #(.LIMIT(X_MAX), .INIT(X_INIT)) u_axis_x (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .load_home (home),
        .spd       (spd_q),
        .pos       (x_pos),
        .bounce    (bounce_x),
        .at_wall   (hit_x)
    );

    axis_stepper #(.LIMIT(Y_MAX), .INIT(Y_INIT)) u_axis_y (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .load_home (home),
        .spd       (spd_q),
        .pos       (y_pos),
        .bounce    (bounce_y),
        .at_wall   (hit_y)
    );

    // Motion FSM with registered moving flag, latched speed and saturating wall-hit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            spd_q      <= 3'd1;
            moving     <= 1'b0;
            bounce_cnt <= 8'd0;
        end else if (home) begin
            state      <= IDLE;
            moving     <= 1'b0;
            bounce_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (!stop && start) begin
                        state  <= RUN;
                        spd_q  <= min_speed(speed);
                        moving <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state  <= HOLD;
                        moving <= 1'b0;
                    end else if (refr_tick) begin
                        bounce_cnt <= cnt_nxt;
                    end
                end
                default: begin
                    state  <= IDLE;
                    moving <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: every driven cycle queues the expected outputs.
// Latency: expectations are due one clock after the inputs are applied.
// Backpressure: n/a.
module tb_sprite_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       refr_tick = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       home = 1'b0;
    logic [2:0] speed = 3'd0;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       moving;
    logic       bounce_x;
    logic       bounce_y;
    logic [7:0] bounce_cnt;

    always #5 clk = ~clk;

    sprite_motion_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .refr_tick  (refr_tick),
        .start      (start),
        .stop       (stop),
        .home       (home),
        .speed      (speed),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .moving     (moving),
        .bounce_x   (bounce_x),
        .bounce_y   (bounce_y),
        .bounce_cnt (bounce_cnt)
    );

    typedef struct {
        int due;
        int x;
        int y;
        bit mv;
        bit bx;
        bit by;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference state: 0 idle, 1 run, 2 hold
    int mst, m_x, m_y, m_spd, m_cnt;
    bit m_dxp, m_dyp, m_mv;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp_v, $time);
        end
    endtask

    task automatic model_home();
        mst = 0; m_x = 300; m_y = 10; m_dxp = 1; m_dyp = 1; m_cnt = 0; m_mv = 0;
    endtask

    task automatic model_reset();
        model_home();
        m_spd = 1;
    endtask

    task automatic ax_step(inout int p, inout bit up, input int lim, input int s, output bit b);
        b = 0;
        if (up) begin
            if (p + s >= lim) begin p = lim; up = 0; b = 1; end
            else p = p + s;
        end else begin
            if (p <= s) begin p = 0; up = 1; b = 1; end
            else p = p - s;
        end
    endtask

    // One clock of stimulus; the reference model advances and the expectation is queued.
    task automatic drive(input bit st, input bit sp, input bit hm, input logic [2:0] spd, input bit tk);
        exp_t e;
        bit   bx, by;
        @(posedge clk);
        #1;
        start = st; stop = sp; home = hm; speed = spd; refr_tick = tk;
        bx = 0; by = 0;
        if (hm) begin
            model_home();
        end else if (mst == 1) begin
            if (sp) begin
                mst = 2; m_mv = 0;
            end else if (tk) begin
                ax_step(m_x, m_dxp, 608, m_spd, bx);
                ax_step(m_y, m_dyp, 464, m_spd, by);
                m_cnt = m_cnt + int'(bx) + int'(by);
                if (m_cnt > 255) m_cnt = 255;
            end
        end else begin
            if (!sp && st) begin
                mst = 1; m_mv = 1;
                m_spd = (spd == 3'd0) ? 1 : int'(spd);
            end
        end
        e.due = cyc + 1; e.x = m_x; e.y = m_y; e.mv = m_mv; e.bx = bx; e.by = by; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        drive(0, 0, 0, 3'd0, 1);
    endtask

    // Idle cycle, then park on the falling edge where the last stimulus is visible.
    task automatic settle();
        drive(0, 0, 0, 3'd0, 0);
        @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: compare the oldest due expectation against the outputs on the falling edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            chk("sb_x_pos", x_pos, e.x);
            chk("sb_y_pos", y_pos, e.y);
            chk("sb_moving", moving, e.mv);
            chk("sb_bounce_x", bounce_x, e.bx);
            chk("sb_bounce_y", bounce_y, e.by);
            chk("sb_bounce_cnt", bounce_cnt, e.cnt);
        end
    end

    initial begin : stim
        int lag_left;
        int xdist, ydist;
        int cnt_before;
        bit found;

        model_reset();
        reset = 1'b1;
        #12;
        chk("rst_x", x_pos, 300);
        chk("rst_y", y_pos, 10);
        chk("rst_moving", moving, 0);
        chk("rst_bounce", {bounce_x, bounce_y}, 0);
        chk("rst_cnt", bounce_cnt, 0);
        @(negedge clk);
        reset = 1'b0;

        // Ticks without start leave the sprite at home
        repeat (10) tick();
        settle();
        chk("idle_x", x_pos, 300);
        chk("idle_y", y_pos, 10);
        chk("idle_moving", moving, 0);
        chk("idle_cnt", bounce_cnt, 0);

        // Run at 3 px/frame, hold, resume
        drive(1, 0, 0, 3'd3, 0);
        repeat (5) tick();
        settle();
        chk("run5_x", x_pos, 315);
        chk("run5_y", y_pos, 25);
        chk("run5_moving", moving, 1);
        drive(0, 1, 0, 3'd0, 0);
        repeat (3) tick();
        settle();
        chk("hold_x", x_pos, 315);
        chk("hold_y", y_pos, 25);
        chk("hold_moving", moving, 0);
        drive(1, 0, 0, 3'd3, 0);
        tick();
        settle();
        chk("resume_x", x_pos, 318);
        chk("resume_y", y_pos, 28);

        // Right wall at speed 7 from x=603
        drive(0, 0, 1, 3'd0, 0);
        drive(1, 0, 0, 3'd3, 0);
        repeat (101) tick();
        settle();
        chk("approach_x", x_pos, 603);
        drive(0, 1, 0, 3'd0, 0);
        drive(1, 0, 0, 3'd7, 0);
        tick();
        settle();
        chk("wall_x", x_pos, 608);
        chk("wall_bounce_x", bounce_x, 1);
        chk("wall_bounce_y", bounce_y, 0);
        chk("wall_cnt", bounce_cnt, 1);
        tick();
        settle();
        chk("rebound_x", x_pos, 601);
        chk("rebound_pulse", bounce_x, 0);

        // Home during RUN clears position and count
        drive(0, 0, 1, 3'd0, 0);
        settle();
        chk("home_x", x_pos, 300);
        chk("home_y", y_pos, 10);
        chk("home_cnt", bounce_cnt, 0);
        chk("home_moving", moving, 0);

        // Speed 0 runs at 1 px/frame
        drive(1, 0, 0, 3'd0, 0);
        tick();
        settle();
        chk("spd0_x", x_pos, 301);
        chk("spd0_y", y_pos, 11);

        // start+stop together from IDLE stays idle
        drive(0, 0, 1, 3'd0, 0);
        drive(1, 1, 0, 3'd5, 0);
        tick();
        settle();
        chk("startstop_moving", moving, 0);
        chk("startstop_x", x_pos, 300);

        // Walk to x=605,y=461 both moving +: speed 1 plus clamped y hits losing 14 px in total
        drive(1, 0, 0, 3'd1, 0);
        lag_left = 14;
        found = 0;
        for (int i = 0; i < 12000 && !found; i++) begin
            xdist = m_dxp ? 608 - m_x : m_x;
            ydist = m_dyp ? 464 - m_y : m_y;
            if (m_x == 605 && m_y == 461 && m_dxp && m_dyp) begin
                found = 1;
            end else if (lag_left > 0 && ydist == 1 && xdist >= 8) begin
                drive(0, 1, 0, 3'd0, 0);
                drive(1, 0, 0, (lag_left >= 6) ? 3'd7 : 3'd3, 0);
                tick();
                lag_left = lag_left - ((lag_left >= 6) ? 6 : 2);
                drive(0, 1, 0, 3'd0, 0);
                drive(1, 0, 0, 3'd1, 0);
            end else begin
                tick();
            end
        end
        chk("corner_reached", found, 1);
        cnt_before = m_cnt;
        drive(0, 1, 0, 3'd0, 0);
        drive(1, 0, 0, 3'd3, 0);
        tick();
        settle();
        chk("corner_x", x_pos, 608);
        chk("corner_y", y_pos, 464);
        chk("corner_pulses", {bounce_x, bounce_y}, 2'b11);
        chk("corner_cnt", bounce_cnt, cnt_before + 2);
        tick();
        settle();
        chk("corner_back_x", x_pos, 605);
        chk("corner_back_y", y_pos, 461);

        // Asynchronous reset overlapping a tick in RUN
        tick();
        #2;
        reset = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        chk("arst_x", x_pos, 300);
        chk("arst_y", y_pos, 10);
        chk("arst_moving", moving, 0);
        chk("arst_pulses", {bounce_x, bounce_y}, 0);
        chk("arst_cnt", bounce_cnt, 0);
        @(posedge clk);
        #1;
        chk("arst_hold_x", x_pos, 300);
        chk("arst_hold_pulses", {bounce_x, bounce_y}, 0);
        refr_tick = 1'b0;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 0, 3'd3, 0);
        tick();
        settle();
        chk("post_rst_x", x_pos, 303);
        chk("post_rst_y", y_pos, 13);
        chk("post_rst_moving", moving, 1);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Sequences position of one 32x16 ROM-based sprite (digit/logo renderer) on the 640x480 VGA frame.
- Sits between the frame-tick generator and sprite renderers; its x_pos/y_pos outputs become the renderers' left/top registers.
- Run/hold/idle FSM; per-frame motion with edge bounce, clamping and bounce counting.

Parameters:
- H_VIS, 640, visible pixels per line
- V_VIS, 480, visible lines per frame
- SPR_W, 32, sprite width in pixels
- SPR_H, 16, sprite height in pixels
- X_INIT, 300, home left position
- Y_INIT, 10, home top position

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  asynchronous, active-high
- refr_tick  in  1  one-cycle pulse at start of vertical blank
- start  in  1  level/pulse; begin or resume motion
- stop  in  1  pulse; freeze motion (hold)
- home  in  1  pulse; return to IDLE at X_INIT/Y_INIT
- speed  in  3  pixels per frame, sampled on entry to RUN; 0 treated as 1
- x_pos  out  10  sprite left edge
- y_pos  out  10  sprite top edge
- moving  out  1  high in RUN
- bounce_x  out  1  one-cycle pulse on horizontal wall hit
- bounce_y  out  1  one-cycle pulse on vertical wall hit
- bounce_cnt  out  8  total wall hits since reset/home, saturating at 255

Behaviour:
- Clock and reset: clk; reset is asynchronous, active-high.
- Reset values: state=IDLE, x_pos=X_INIT, y_pos=Y_INIT, dir_x=+1, dir_y=+1, spd_q=1, moving=0, bounce_x=0, bounce_y=0, bounce_cnt=0.
- Limits: X_MAX=H_VIS-SPR_W (608), Y_MAX=V_VIS-SPR_H (464). Position always within [0, X_MAX] x [0, Y_MAX].
- States:
  - IDLE: position held at home. start -> RUN; spd_q <= max(speed,1).
  - RUN: on refr_tick only, x and y each step by spd_q in their current direction. stop -> HOLD. home -> IDLE.
  - HOLD: position/direction frozen. start -> RUN with speed resampled. home -> IDLE.
- Priority when multiple controls are asserted in the same cycle: home > stop > start.
- A refr_tick coinciding with a transition out of RUN is ignored (no step). A refr_tick coinciding with IDLE/HOLD->RUN is also ignored; the first step occurs on the next tick.
- Step arithmetic uses an 11-bit signed intermediate:
  - Moving +: if x+spd_q >= X_MAX then x<=X_MAX, dir_x<=-1, bounce_x=1; else x<=x+spd_q.
  - Moving -: if x <= spd_q then x<=0, dir_x<=+1, bounce_x=1; else x<=x-spd_q.
  - Same rule for y with Y_MAX/bounce_y.
  - Landing exactly on a limit counts as a bounce.
- Corner hit: bounce_x and bounce_y pulse in the same cycle; bounce_cnt += 2 (saturating).
- Timing: outputs are registered. x_pos/y_pos update in the cycle after refr_tick. Bounce pulses are high for exactly that one cycle. moving is high in the cycle after entry to RUN.
- home: x/y <= INIT, dir <= +1/+1, bounce_cnt <= 0, moving <= 0, all next cycle.
- Reset mid-motion: immediate asynchronous return to reset values, with no bounce pulse.
- Updates occur only on refr_tick (vertical blank), so no mid-frame tearing.

Decomposition:
- Shared package (vga_pkg): H_VIS, V_VIS, 10-bit coordinate typedef, state enum {IDLE, RUN, HOLD}.
- One natural sub-module: axis_stepper (position/direction/bounce for one axis, parameterised by limit and init). Instantiate twice, for x and y.
- FSM and bounce counter live in the top module.

Test Plan:
- Reset, then 10 refr_ticks with no start -> x_pos=300, y_pos=10, moving=0, bounce_cnt=0.
- start with speed=3, then 5 ticks -> x_pos=315, y_pos=25, moving=1. stop, then 3 ticks -> position stays 315/25, moving=0. start resumes motion.
- speed=7 with x approaching 608 (x=603): one tick -> x_pos=608, bounce_x pulses 1 cycle, bounce_cnt=1; next tick -> x_pos=601.
- Corner: x=605, y=461, speed=3, both directions + -> x=608, y=464, both pulses in the same cycle, bounce_cnt +2; next tick -> 605/461.
- speed=0 at start -> 1 px/frame. start+stop in the same cycle from IDLE -> stays IDLE. home during RUN -> 300/10, bounce_cnt=0.
- Assert reset mid-RUN, overlapping a refr_tick -> outputs at reset values immediately with no bounce pulse; after release, start resumes from 300/10.
